// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch stage: holds the PC, issues one word fetch at a time, buffers the returned instruction.
// Latency: request in ISSUE, response >=1 cycle later, instruction valid the cycle after it returns (3 cycles/instr at best).
// Backpressure: inst_valid/inst_ready; while the buffer is held no new fetch is issued; redirects win over everything.
module instr_fetch_unit #(
    parameter logic [63:0] PC_RESET = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [63:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_base,
    input  logic [63:0] BusImm
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [63:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;

    logic [63:0] target;
    logic [63:0] pc_inc;

    // Branch target is word-scaled offset added to the branching PC; sequential PC wraps mod 2^64.
    assign target = redirect_base + (BusImm << 2);
    assign pc_inc = pc_q + 64'd4;

    // State register: all flops, synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= S_ISSUE;
            pc_q         <= PC_RESET;
            inst_out_q   <= 32'h0;
            inst_pc_q    <= 64'h0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Next-state logic: redirect takes priority over imem_rvalid and inst_ready in every state.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        case (state_q)
            S_ISSUE: begin
                // The request goes out this cycle; a redirect makes it wrong-path, so drain it.
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_rvalid ? S_ISSUE : S_DRAIN;
                end else if (imem_rvalid) begin
                    inst_out_d   = imem_rdata;
                    inst_pc_d    = pc_q;
                    pc_d         = pc_inc;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    inst_valid_d = 1'b0;
                    pc_d         = target;
                    state_d      = S_ISSUE;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_ISSUE;
                end
            end
            S_DRAIN: begin
                // Stale response is dropped; redirects here only retarget the PC.
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_rvalid) begin
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_ISSUE;
        endcase
    end

    // Outputs: request only in ISSUE and never during reset; held instruction hidden in a redirect cycle.
    always_comb begin
        imem_req   = (state_q == S_ISSUE) && !Reset;
        imem_addr  = pc_q;
        inst_out   = inst_out_q;
        inst_pc    = inst_pc_q;
        inst_valid = inst_valid_q & ~redirect;
    end

endmodule
